// File: rtl/peri_gpio_tlul.sv
// +----------------------------------------------------------------------------+
// | peri_gpio_tlul : TL-UL GPIO with per-pin OE, input sync, set/clear writes   |
// | Optional edge interrupts enabled by defining PERI_GPIO_INTR_EN.             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package tlul_pkg;
  localparam logic [2:0] c_PUT_FULL        = 3'd0;
  localparam logic [2:0] c_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] c_GET             = 3'd4;
  localparam logic [2:0] c_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] c_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module peri_gpio_tlul #(
  parameter int Width = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  tlul_pkg::tl_h2d_t    tl_i,
  output tlul_pkg::tl_d2h_t    tl_o,
  input  logic [Width-1:0]     gpio_i,
  output logic [Width-1:0]     gpio_o,
  output logic [Width-1:0]     gpio_oe_o,
  output logic                 intr_o
);
  import tlul_pkg::*;

  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;

  state_e            r_state;
  logic              r_a_ready;
  logic              r_d_valid;
  logic [2:0]        r_d_opcode;
  logic [1:0]        r_d_size;
  logic [7:0]        r_d_source;
  logic [31:0]       r_d_data;
  logic              r_d_error;

  logic [Width-1:0]  r_data_out;
  logic [Width-1:0]  r_oe;
  logic [Width-1:0]  r_sync1;
  logic [Width-1:0]  r_sync2;

  logic              w_accept;
  logic              w_is_get;
  logic              w_is_put;
  logic              w_addr_ok;
  logic              w_err;
  logic              w_wr;
  logic [2:0]        w_idx;
  logic [31:0]       w_bmask;
  logic [Width-1:0]  w_wmask;
  logic [Width-1:0]  w_wdata;
  logic [31:0]       w_rdata;
  logic [Width-1:0]  w_data_out_nxt;
  logic [Width-1:0]  w_oe_nxt;

  function automatic logic [Width-1:0] f_merge(input logic [Width-1:0] old_v,
                                               input logic [Width-1:0] new_v,
                                               input logic [Width-1:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign w_accept  = (r_state == ST_IDLE) && tl_i.a_valid;
  assign w_is_get  = (tl_i.a_opcode == c_GET);
  assign w_is_put  = (tl_i.a_opcode == c_PUT_FULL) || (tl_i.a_opcode == c_PUT_PARTIAL);
  assign w_addr_ok = (tl_i.a_address[31:5] == 27'd0) && (tl_i.a_address[1:0] == 2'b00);
  assign w_err     = !(w_addr_ok && (w_is_get || w_is_put));
  assign w_wr      = w_accept && w_is_put && !w_err;
  assign w_idx     = tl_i.a_address[4:2];
  assign w_bmask   = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                      {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};
  assign w_wmask   = w_bmask[Width-1:0];
  assign w_wdata   = tl_i.a_data[Width-1:0];

`ifdef PERI_GPIO_INTR_EN
  logic [Width-1:0]  r_prev;
  logic [Width-1:0]  r_intr_state;
  logic [Width-1:0]  r_intr_enable;
  logic [Width-1:0]  r_intr_rise;
  logic [Width-1:0]  w_edge;
  logic [Width-1:0]  w_w1c;

  assign w_edge = ( r_intr_rise &  r_sync2 & ~r_prev) |
                  (~r_intr_rise & ~r_sync2 &  r_prev);
  assign w_w1c  = (w_wr && (w_idx == 3'd5)) ? (w_wdata & w_wmask) : '0;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prev        <= '0;
      r_intr_state  <= '0;
      r_intr_enable <= '0;
      r_intr_rise   <= '0;
    end else begin
      r_prev       <= r_sync2;
      r_intr_state <= (r_intr_state & ~w_w1c) | w_edge;
      if (w_wr && (w_idx == 3'd6)) r_intr_enable <= f_merge(r_intr_enable, w_wdata, w_wmask);
      if (w_wr && (w_idx == 3'd7)) r_intr_rise   <= f_merge(r_intr_rise, w_wdata, w_wmask);
    end
  end

  assign intr_o = |(r_intr_state & r_intr_enable);
`else
  assign intr_o = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = 32'(r_data_out);
      3'd1:    w_rdata = 32'(r_sync2);
      3'd2:    w_rdata = 32'(r_oe);
`ifdef PERI_GPIO_INTR_EN
      3'd5:    w_rdata = 32'(r_intr_state);
      3'd6:    w_rdata = 32'(r_intr_enable);
      3'd7:    w_rdata = 32'(r_intr_rise);
`endif
      default: w_rdata = '0;
    endcase
  end

  always_comb begin
    w_data_out_nxt = r_data_out;
    w_oe_nxt       = r_oe;
    if (w_wr) begin
      case (w_idx)
        3'd0:    w_data_out_nxt = f_merge(r_data_out, w_wdata, w_wmask);
        3'd2:    w_oe_nxt       = f_merge(r_oe, w_wdata, w_wmask);
        3'd3:    w_data_out_nxt = r_data_out | (w_wdata & w_wmask);
        3'd4:    w_data_out_nxt = r_data_out & ~(w_wdata & w_wmask);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_a_ready  <= 1'b1;
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
      r_data_out <= '0;
      r_oe       <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
    end else begin
      r_sync1    <= gpio_i;
      r_sync2    <= r_sync1;
      r_data_out <= w_data_out_nxt;
      r_oe       <= w_oe_nxt;
      case (r_state)
        ST_IDLE: begin
          if (tl_i.a_valid) begin
            r_state    <= ST_RESP;
            r_a_ready  <= 1'b0;
            r_d_valid  <= 1'b1;
            r_d_opcode <= w_is_get ? c_ACCESS_ACK_DATA : c_ACCESS_ACK;
            r_d_size   <= tl_i.a_size;
            r_d_source <= tl_i.a_source;
            r_d_data   <= (w_is_get && !w_err) ? w_rdata : 32'd0;
            r_d_error  <= w_err;
          end
        end
        ST_RESP: begin
          if (tl_i.d_ready) begin
            r_state   <= ST_IDLE;
            r_a_ready <= 1'b1;
            r_d_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign tl_o.d_valid  = r_d_valid;
  assign tl_o.d_opcode = r_d_opcode;
  assign tl_o.d_size   = r_d_size;
  assign tl_o.d_source = r_d_source;
  assign tl_o.d_data   = r_d_data;
  assign tl_o.d_error  = r_d_error;
  assign tl_o.a_ready  = r_a_ready;

  assign gpio_o    = r_data_out;
  assign gpio_oe_o = r_oe;

endmodule

`default_nettype wire

// File: tb/tb_peri_gpio_tlul.sv
// Self-checking bench for peri_gpio_tlul (Width=16): vector table, scoreboard
// of expected TL-UL responses, and hand sequences for multi-cycle corners.
`default_nettype none

module tb_peri_gpio_tlul;
  import tlul_pkg::*;

  localparam int W = 16;
  localparam logic [2:0] OP_PF = 3'd0, OP_PP = 3'd1, OP_GET = 3'd4;

  logic             clk = 1'b0;
  logic             rst_n;
  tl_h2d_t          tl_i;
  tl_d2h_t          tl_o;
  logic [W-1:0]     gpio_i;
  logic [W-1:0]     gpio_o;
  logic [W-1:0]     gpio_oe;
  logic             intr;

  int checks = 0;
  int errors = 0;
  logic [7:0] tag = 8'd0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [2:0]  opc;
    logic [7:0]  src;
    logic [1:0]  size;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [31:0]  addr;
    logic [3:0]   mask;
    logic [31:0]  wdata;
    logic [31:0]  exp_d;
    logic         exp_e;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_oe;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  peri_gpio_tlul #(.Width(W)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tl_i      (tl_i),
    .tl_o      (tl_o),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_o (gpio_oe),
    .intr_o    (intr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [2:0] op, input logic [31:0] addr,
                               input logic [3:0] mask, input logic [31:0] wdata,
                               input logic [31:0] exp_d, input logic exp_e,
                               input logic [W-1:0] exp_out, input logic [W-1:0] exp_oe);
    vec_t v;
    v.op = op; v.addr = addr; v.mask = mask; v.wdata = wdata;
    v.exp_d = exp_d; v.exp_e = exp_e; v.exp_out = exp_out; v.exp_oe = exp_oe;
    return v;
  endfunction

  // Response monitor: compares every handshaken response against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && tl_o.d_valid && tl_i.d_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("d_data",   tl_o.d_data, e.data);
        chk("d_error",  32'(tl_o.d_error), 32'(e.err));
        chk("d_opcode", 32'(tl_o.d_opcode), 32'(e.opc));
        chk("d_source", 32'(tl_o.d_source), 32'(e.src));
        chk("d_size",   32'(tl_o.d_size), 32'(e.size));
      end
    end
  end

  // Called #1 after a posedge with the DUT idle; returns #1 after the response is consumed.
  task automatic xact(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] wdata, input logic [31:0] exp_d, input logic exp_e,
                      input logic chk_out, input logic [W-1:0] exp_out, input logic [W-1:0] exp_oe);
    exp_t e;
    int n;
    tag++;
    e.data = exp_d; e.err = exp_e; e.opc = (op == OP_GET) ? 3'd1 : 3'd0;
    e.src = tag; e.size = 2'd2;
    exp_q.push_back(e);
    tl_i.a_valid = 1'b1; tl_i.a_opcode = op; tl_i.a_address = addr;
    tl_i.a_mask = mask; tl_i.a_data = wdata; tl_i.a_source = tag; tl_i.a_size = 2'd2;
    n = 0;
    forever begin
      @(negedge clk);
      if (tl_o.a_ready) break;
      n++;
      if (n > 20) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    if (chk_out) begin
      chk("gpio_o_at_dvalid", 32'(gpio_o), 32'(exp_out));
      chk("gpio_oe_at_dvalid", 32'(gpio_oe), 32'(exp_oe));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    rst_n = 1'b0;
    gpio_i = 16'h5A3C;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_d_error", 32'(tl_o.d_error), 32'd0);
    chk("rst_d_data",  tl_o.d_data, 32'd0);
    chk("rst_gpio_o",  32'(gpio_o), 32'd0);
    chk("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    chk("rst_intr",    32'(intr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Vector table
    vecs.push_back(mkv(OP_PF,  32'h00, 4'hF, 32'hA5A5_A5A5, 32'h0,         1'b0, 16'hA5A5, 16'h0000));
    vecs.push_back(mkv(OP_GET, 32'h00, 4'hF, 32'h0,         32'h0000_A5A5, 1'b0, 16'hA5A5, 16'h0000));
    vecs.push_back(mkv(OP_PF,  32'h00, 4'hF, 32'h0000_00F0, 32'h0,         1'b0, 16'h00F0, 16'h0000));
    vecs.push_back(mkv(OP_PF,  32'h0C, 4'hF, 32'h0000_000F, 32'h0,         1'b0, 16'h00FF, 16'h0000));
    vecs.push_back(mkv(OP_GET, 32'h0C, 4'hF, 32'h0,         32'h0,         1'b0, 16'h00FF, 16'h0000));
    vecs.push_back(mkv(OP_PF,  32'h10, 4'hF, 32'h0000_0030, 32'h0,         1'b0, 16'h00CF, 16'h0000));
    vecs.push_back(mkv(OP_GET, 32'h10, 4'hF, 32'h0,         32'h0,         1'b0, 16'h00CF, 16'h0000));
    vecs.push_back(mkv(OP_PP,  32'h00, 4'b0010, 32'h0000_FF00, 32'h0,      1'b0, 16'hFFCF, 16'h0000));
    vecs.push_back(mkv(OP_GET, 32'h00, 4'hF, 32'h0,         32'h0000_FFCF, 1'b0, 16'hFFCF, 16'h0000));
    vecs.push_back(mkv(OP_PF,  32'h08, 4'hF, 32'hFFFF_1234, 32'h0,         1'b0, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(OP_GET, 32'h08, 4'hF, 32'h0,         32'h0000_1234, 1'b0, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(OP_GET, 32'h24, 4'hF, 32'h0,         32'h0,         1'b1, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(OP_PF,  32'h20, 4'hF, 32'h0,         32'h0,         1'b1, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(OP_GET, 32'h02, 4'hF, 32'h0,         32'h0,         1'b1, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(3'd2,   32'h00, 4'hF, 32'h0,         32'h0,         1'b1, 16'hFFCF, 16'h1234));
    vecs.push_back(mkv(OP_PF,  32'h0C, 4'b0001, 32'hFFFF_FFFF, 32'h0,      1'b0, 16'hFFFF, 16'h1234));
    vecs.push_back(mkv(OP_PF,  32'h10, 4'b0010, 32'hFFFF_FFFF, 32'h0,      1'b0, 16'h00FF, 16'h1234));
    vecs.push_back(mkv(OP_PP,  32'h08, 4'b0001, 32'h0,      32'h0,         1'b0, 16'h00FF, 16'h1200));
    vecs.push_back(mkv(OP_GET, 32'h04, 4'hF, 32'h0,         32'h0000_5A3C, 1'b0, 16'h00FF, 16'h1200));
    vecs.push_back(mkv(OP_GET, 32'h18, 4'hF, 32'h0,         32'h0,         1'b0, 16'h00FF, 16'h1200));
    vecs.push_back(mkv(OP_PF,  32'h18, 4'hF, 32'hFFFF_FFFF, 32'h0,         1'b0, 16'h00FF, 16'h1200));
`ifdef PERI_GPIO_INTR_EN
    vecs.push_back(mkv(OP_GET, 32'h18, 4'hF, 32'h0,         32'h0000_FFFF, 1'b0, 16'h00FF, 16'h1200));
`else
    vecs.push_back(mkv(OP_GET, 32'h18, 4'hF, 32'h0,         32'h0,         1'b0, 16'h00FF, 16'h1200));
`endif
    vecs.push_back(mkv(OP_GET, 32'h1C, 4'hF, 32'h0,         32'h0,         1'b0, 16'h00FF, 16'h1200));

    foreach (vecs[i])
      xact(vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].wdata, vecs[i].exp_d,
           vecs[i].exp_e, 1'b1, vecs[i].exp_out, vecs[i].exp_oe);

    // Input sync latency: read accepted at K+1 misses the edge, at K+2 sees it
    gpio_i[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    gpio_i[3] = 1'b1;
    @(posedge clk); #1;
    xact(OP_GET, 32'h04, 4'hF, 32'h0, 32'h0000_5A34, 1'b0, 1'b0, '0, '0);
    gpio_i[3] = 1'b0;
    repeat (4) @(posedge clk); #1;
    gpio_i[3] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    xact(OP_GET, 32'h04, 4'hF, 32'h0, 32'h0000_5A3C, 1'b0, 1'b0, '0, '0);

`ifdef PERI_GPIO_INTR_EN
    xact(OP_PF, 32'h1C, 4'hF, 32'h1, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_PF, 32'h18, 4'hF, 32'h1, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_PF, 32'h14, 4'hF, 32'hFFFF, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_GET, 32'h1C, 4'hF, 32'h0, 32'h1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("intr_after_clear_all", 32'(intr), 32'd0);
    @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("intr_latency_k", 32'(intr), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("intr_latency_k1", 32'(intr), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("intr_latency_k2", 32'(intr), 32'd1);
    @(posedge clk); #1;
    gpio_i[0] = 1'b0;
    xact(OP_GET, 32'h14, 4'hF, 32'h0, 32'h1, 1'b0, 1'b0, '0, '0);
    xact(OP_PF, 32'h14, 4'hF, 32'h1, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("intr_after_w1c", 32'(intr), 32'd0);
    // W1C accepted on the same edge that latches a new rising edge
    repeat (4) @(posedge clk); #1;
    gpio_i[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    xact(OP_PF, 32'h14, 4'hF, 32'h1, 32'h0, 1'b0, 1'b0, '0, '0);
    chk("intr_set_wins", 32'(intr), 32'd1);
    xact(OP_GET, 32'h14, 4'hF, 32'h0, 32'h1, 1'b0, 1'b0, '0, '0);
    // Falling-edge selection; changing polarity alone must not fire
    xact(OP_PF, 32'h14, 4'hF, 32'h1, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_PF, 32'h1C, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("intr_no_spurious_polarity", 32'(intr), 32'd0);
    @(posedge clk); #1;
    gpio_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("intr_falling_edge", 32'(intr), 32'd1);
    @(posedge clk); #1;
`else
    for (int i = 0; i < 6; i++) begin
      gpio_i = ~gpio_i;
      @(negedge clk);
      chk("intr_tied_low", 32'(intr), 32'd0);
      @(posedge clk); #1;
    end
    xact(OP_GET, 32'h14, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_PF,  32'h14, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, '0, '0);
    xact(OP_GET, 32'h1C, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0, '0, '0);
`endif

    // Backpressure: response held for 5 cycles with a competing request pending
    begin
      exp_t e;
      tl_i.d_ready = 1'b0;
      tag++;
      e.data = 32'h0000_00FF; e.err = 1'b0; e.opc = 3'd1; e.src = tag; e.size = 2'd2;
      exp_q.push_back(e);
      tl_i.a_valid = 1'b1; tl_i.a_opcode = OP_GET; tl_i.a_address = 32'h0;
      tl_i.a_mask = 4'hF; tl_i.a_data = 32'h0; tl_i.a_source = tag; tl_i.a_size = 2'd2;
      @(posedge clk); #1;
      tl_i.a_opcode = OP_PF; tl_i.a_source = 8'hEE;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("stall_d_valid",  32'(tl_o.d_valid), 32'd1);
        chk("stall_a_ready",  32'(tl_o.a_ready), 32'd0);
        chk("stall_d_data",   tl_o.d_data, 32'h0000_00FF);
        chk("stall_d_source", 32'(tl_o.d_source), 32'(e.src));
        chk("stall_gpio_o",   32'(gpio_o), 32'h0000_00FF);
        @(posedge clk); #1;
      end
      tl_i.a_valid = 1'b0;
      tl_i.d_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("release_a_ready", 32'(tl_o.a_ready), 32'd1);
      chk("release_d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("release_gpio_o",  32'(gpio_o), 32'h0000_00FF);
      @(posedge clk); #1;
    end

    // Reset while a response is pending
    tl_i.d_ready = 1'b0;
    tl_i.a_valid = 1'b1; tl_i.a_opcode = OP_GET; tl_i.a_address = 32'h0; tl_i.a_source = 8'h77;
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("midrst_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("midrst_gpio_o",  32'(gpio_o), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tl_i.d_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    xact(OP_GET, 32'h00, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 16'h0000, 16'h0000);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/peri_gpio_tlul.md
# peri_gpio_tlul

Parametrised TL-UL GPIO peripheral and the successor to the fixed 32-bit output-only GPIO in the peripheral device. It sits on the `tl_peri_device` port of `xbar_main`. It adds:
- configurable pin count;
- per-pin output enable;
- two-flop input synchronisation;
- atomic set/clear writes;
- optional edge-triggered interrupts.

It has one outstanding TL-UL transaction and a single-cycle response.

## Interface
Parameters:
- `Width`, 32, number of GPIO pins, legal range 1..32.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, **synchronous, active-low**.
- `tl_i` in `tlul_pkg::tl_h2d_t`: TL-UL request from the crossbar.
- `tl_o` out `tlul_pkg::tl_d2h_t`: TL-UL response to the crossbar.
- `gpio_i` in `Width`: asynchronous pin inputs.
- `gpio_o` out `Width`: output data.
- `gpio_oe_o` out `Width`: per-pin output enable (1 = drive).
- `intr_o` out 1: level interrupt. Present only with `PERI_GPIO_INTR_EN`; tied 0 otherwise.

## Operation
- **Register map** (word offsets, bits ≥ `Width` read 0 and ignore writes):
  - 0x00 `DATA_OUT` RW.
  - 0x04 `DATA_IN` RO: synchronised pins.
  - 0x08 `OE` RW.
  - 0x0C `SET` WO: `DATA_OUT |= wdata`.
  - 0x10 `CLR` WO: `DATA_OUT &= ~wdata`.
  - 0x14 `INTR_STATE` RW1C.
  - 0x18 `INTR_ENABLE` RW.
  - 0x1C `INTR_RISE` RW: 1 = rising edge, 0 = falling edge, per pin.
- **Write-only registers** read 0.
- **Without the macro**, 0x14–0x1C read 0, ignore writes and give no error.
- **Byte masks:** `a_mask` byte enables apply to RW, SET, CLR and W1C writes. Masked-off bytes are unchanged.
- **Opcodes:**
  - Get (4) → AccessAckData (1).
  - PutFullData (0) and PutPartialData (1) → AccessAck (0).
  - `d_source` and `d_size` echo the request.
- **Error response:** any other opcode, an address ≥ 0x20, or an address not word-aligned gives `d_error`=1, `d_data`=0, and no state change.
- **Transaction FSM:**
  - IDLE: `a_ready`=1. On `a_valid` go to RESP and perform the access.
  - RESP: `a_ready`=0, `d_valid`=1. On `d_ready` return to IDLE.
  - `a_ready` is low during RESP, so there are no back-to-back accepts without an IDLE cycle.
- **Input path:** `gpio_i` → `sync1` → `sync2`, with `prev` ← `sync2`. `DATA_IN` = `sync2`.
- **Edge detect:**
  - rise = `sync2 & ~prev`; fall = `~sync2 & prev`.
  - `INTR_STATE[i]` is set when the selected edge occurs, regardless of `INTR_ENABLE`.
- **Simultaneous events:** if a hardware edge and a W1C write hit the same bit in the same cycle, the set wins and the bit stays 1.
- `intr_o` = |(`INTR_STATE` & `INTR_ENABLE`), driven combinationally from registers.

## Timing
- **Reset values** (all registers and outputs):
  - All registers 0: `gpio_o`=0, `gpio_oe_o`=0, `intr_o`=0.
  - Sync and `prev` flops 0.
  - `a_ready`=1, `d_valid`=0, `d_error`=0, `d_data`=0.
- **Read latency:** the access is accepted at edge N and `d_valid` and `d_data` are valid after edge N. Read data is sampled at acceptance.
- **Write timing:** a write accepted at edge N updates the register, and therefore `gpio_o`/`gpio_oe_o`, at edge N, in the same cycle `d_valid` rises.
- **Input latency:** a `gpio_i` change stable before edge K is visible in `DATA_IN` after edge K+1.
- **Interrupt latency:** the matching `INTR_STATE` bit is set after edge K+2, and `intr_o` follows in the same cycle.
- **Holding responses:** `d_valid` and all `d_*` fields hold stable until `d_ready`. A stalled response blocks new requests indefinitely. Inputs keep being synchronised and interrupts keep latching while stalled.
- **Reset mid-transaction:** returns the FSM to IDLE and discards the pending response.
- **Changing `INTR_RISE`:** no spurious edge is generated. Detection uses `sync2`/`prev` only.

## Configuration
- `PERI_GPIO_INTR_EN` defined: edge detection, `INTR_STATE`/`INTR_ENABLE`/`INTR_RISE` and `intr_o` are implemented.
- Not defined: that logic is removed, `intr_o`=0 constantly, and offsets 0x14–0x1C read 0 with no error. DATA, OE, SET, CLR and input synchronisation are unchanged.

## Test plan
- **Reset and write/readback:**
  - Stimulus: reset, then PutFull 0x00 `0xA5A5_A5A5` with `Width`=16, then Get 0x00.
  - Required: `gpio_o`=0xA5A5 the cycle `d_valid` rises; readback `d_data`=0x0000_A5A5; `d_error`=0.
- **Set/clear/partial:**
  - Stimulus: `DATA_OUT`=0x00F0; SET 0x000F; CLR 0x0030; PutPartial 0x00 with `a_mask`=0b0010 and data 0xFF00.
  - Required: `DATA_OUT` goes 0x00FF → 0x00CF → 0xFFCF.
- **Input sync latency:**
  - Stimulus: drive `gpio_i[3]` 0→1 before edge K; Get 0x04 accepted at K+1 and at K+2.
  - Required: the first read returns bit3=0 and the second returns bit3=1.
- **Interrupts (macro defined):**
  - Stimulus: `INTR_RISE`=0x1, `INTR_ENABLE`=0x1, pulse `gpio_i[0]` high.
  - Required: `intr_o`=1 two edges after sync.
  - Stimulus: write 1 to 0x14.
  - Required: `intr_o`=0.
  - Stimulus: a W1C write coinciding with a new edge.
  - Required: bit remains 1.
- **Error and backpressure:**
  - Stimulus: Get 0x24.
  - Required: `d_error`=1, `d_data`=0.
  - Stimulus: hold `d_ready`=0 for 5 cycles.
  - Required: `d_*` stable and `a_ready`=0 throughout; IDLE the cycle after `d_ready`.
- **Macro undefined:**
  - Stimulus: write 0xFFFF_FFFF to 0x18, then toggle inputs.
  - Required: reading 0x18 returns 0, `intr_o` stays 0, and no `d_error`.
